// File: rtl/gemv_q8_pkg.sv
// Shared types and default dimensions for the q8 GEMV command sequencer.
package gemv_q8_pkg;

    localparam int DEF_ROW_W     = 16;
    localparam int DEF_BLK_W     = 12;
    localparam int DEF_MAX_OUTST = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [DEF_ROW_W-1:0] row;
        logic [DEF_BLK_W-1:0] blk;
        logic                 first;
        logic                 last;
    } blk_cmd_t;

endpackage

// File: rtl/gemv_q8_credit_cnt.sv
// Rows-in-flight credit counter: up on issued row, down on returned result,
// never wraps; a decrement while empty is reported as underflow.
module gemv_q8_credit_cnt #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic empty,
    output logic empty_next,
    output logic underflow
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full       = (cnt_q == CW'(MAX));
    assign empty      = (cnt_q == '0);
    assign empty_next = (cnt_d == '0);
    assign underflow  = dec && empty;

endmodule

// File: rtl/gemv_q8_sched.sv
// Block-command sequencer for the q8 GEMV datapath: walks (row, block),
// throttles rows in flight by credit, counts returned rows, reports completion.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | emitting block commands while credit is available
// DRAIN | all commands issued, waiting for the remaining row results
// DONE  | one-cycle completion (err too when the job had a zero dimension)
module gemv_q8_sched import gemv_q8_pkg::*; #(
    parameter int ROW_W     = DEF_ROW_W,
    parameter int BLK_W     = DEF_BLK_W,
    parameter int MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic [ROW_W-1:0] n_rows,
    input  logic [BLK_W-1:0] n_blks,
    input  logic             abort,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [ROW_W-1:0] cmd_row,
    output logic [BLK_W-1:0] cmd_blk,
    output logic             cmd_first,
    output logic             cmd_last,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ROW_W-1:0] rows_done
);

    sched_state_e     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [ROW_W-1:0] n_rows_q, n_rows_d;
    logic [BLK_W-1:0] n_blks_q, n_blks_d;
    logic [ROW_W-1:0] rows_done_q, rows_done_d;
    logic             zero_err_q, zero_err_d;
    logic             busy_q, busy_d;

    logic hs;
    logic credit_clr;
    logic credit_full;
    logic credit_empty;
    logic credit_empty_next;
    logic credit_underflow;

    gemv_q8_credit_cnt #(
        .MAX (MAX_OUTST)
    ) u_credit (
        .clk        (ACLK),
        .rst        (ARESET),
        .inc        (hs && cmd_last),
        .dec        (res_valid),
        .clr        (credit_clr),
        .full       (credit_full),
        .empty      (credit_empty),
        .empty_next (credit_empty_next),
        .underflow  (credit_underflow)
    );

    assign cmd_valid = (state_q == ISSUE) && !credit_full;
    assign hs        = cmd_valid && cmd_ready;
    assign cmd_row   = row_q;
    assign cmd_blk   = blk_q;
    assign cmd_first = (state_q == ISSUE) && (blk_q == '0);
    assign cmd_last  = (state_q == ISSUE) && (blk_q == n_blks_q - 1'b1);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        blk_d       = blk_q;
        n_rows_d    = n_rows_q;
        n_blks_d    = n_blks_q;
        rows_done_d = rows_done_q;
        zero_err_d  = zero_err_q;
        credit_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    n_rows_d    = n_rows;
                    n_blks_d    = n_blks;
                    row_d       = '0;
                    blk_d       = '0;
                    rows_done_d = '0;
                    credit_clr  = 1'b1;
                    if ((n_rows != '0) && (n_blks != '0)) begin
                        state_d    = ISSUE;
                        zero_err_d = 1'b0;
                    end else begin
                        state_d    = DONE;
                        zero_err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (hs) begin
                    if (cmd_last) begin
                        blk_d = '0;
                        if (row_q == n_rows_q - 1'b1) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        blk_d = blk_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Uses the post-update count so a result in this cycle finishes the job.
                if (credit_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (res_valid && !credit_underflow && ((state_q == ISSUE) || (state_q == DRAIN))) begin
            rows_done_d = rows_done_q + 1'b1;
        end

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            row_q       <= '0;
            blk_q       <= '0;
            n_rows_q    <= '0;
            n_blks_q    <= '0;
            rows_done_q <= '0;
            zero_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            blk_q       <= blk_d;
            n_rows_q    <= n_rows_d;
            n_blks_q    <= n_blks_d;
            rows_done_q <= rows_done_d;
            zero_err_q  <= zero_err_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign rows_done = rows_done_q;
    assign done      = (state_q == DONE) && !abort;
    assign err       = credit_underflow || (done && zero_err_q);

endmodule

// File: doc/gemv_q8_sched.md
# gemv_q8_sched

Command sequencer for the q8 GEMV datapath. It takes a job of `n_rows` output rows by `n_blks` 32-element q8 weight blocks per row and issues one block command per (row, block) to the MAC datapath. It limits the number of rows in flight with a credit counter, counts per-row results, and reports completion. It sits between the AXI4-Lite register file (start, dimensions, status) and the MAC/accumulator pipeline.

## Interface
- `ROW_W`, 16, width of the row count and row index
- `BLK_W`, 12, width of the block count and block index
- `MAX_OUTST`, 4, maximum rows issued whose result has not yet returned (≥1)

Ports:
- `ACLK`  in  1  clock
- `ARESET`  in  1  reset; synchronous, active-high
- `start`  in  1  job start pulse; sampled only in IDLE
- `n_rows`  in  ROW_W  rows in the job; sampled with `start`
- `n_blks`  in  BLK_W  blocks per row; sampled with `start`
- `abort`  in  1  cancel the current job
- `cmd_valid`  out  1  block command valid
- `cmd_ready`  in  1  datapath accepts the command
- `cmd_row`  out  ROW_W  row index of the command
- `cmd_blk`  out  BLK_W  block index of the command
- `cmd_first`  out  1  command is block 0 of its row (clear accumulator)
- `cmd_last`  out  1  command is block `n_blks-1` of its row (emit result)
- `res_valid`  in  1  one pulse per finished row; no backpressure
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle job-complete pulse
- `err`  out  1  one-cycle error pulse
- `rows_done`  out  ROW_W  rows completed in the current or last job

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start` when both dims are nonzero. On entry: latch the dims, zero the row/block indices, zero `rows_done`, zero the credit counter.
- IDLE → DONE on `start` with `n_rows==0` or `n_blks==0`. The DONE cycle then asserts `done` and `err` together.
- ISSUE:
  - `cmd_valid = (outst < MAX_OUTST)`.
  - On each handshake, `cmd_blk` increments. At `n_blks-1` it wraps to 0 and `cmd_row` increments.
  - `cmd_first = (cmd_blk==0)`; `cmd_last = (cmd_blk==n_blks_q-1)`. Both are set together when `n_blks==1`.
  - The handshake with `cmd_last` on row `n_rows-1` moves the FSM to DRAIN.
- Credit counter `outst`:
  - +1 on a handshake carrying `cmd_last`.
  - −1 on `res_valid`.
  - Unchanged when both occur in the same cycle.
- `res_valid` increments `rows_done` in ISSUE and DRAIN.
- `res_valid` while `outst==0` is a protocol error: pulse `err`, leave counters unchanged.
- DRAIN → DONE when `outst==0`. This also covers the case where the final `res_valid` arrives in the same cycle.
- DONE: `done=1` for one cycle, then IDLE. `rows_done` holds until the next start.
- `start` outside IDLE is ignored.
- `abort` in ISSUE, DRAIN or DONE: next state is IDLE with `cmd_valid` low. This is the only permitted drop of `cmd_valid` without a handshake. No `done` pulse. `rows_done` retains its value. `abort` in IDLE has no effect.
- `abort` takes priority over `start` and over all other transitions.

## Timing
- Reset values: state IDLE; all outputs 0; indices, `rows_done` and `outst` all 0.
- A `start` in cycle t gives `cmd_valid` in cycle t+1 (registered).
- While `cmd_valid && !cmd_ready`, `cmd_row`, `cmd_blk`, `cmd_first` and `cmd_last` hold stable.
- Sustained issue is one command per cycle when `cmd_ready` is high and credit is available.
- A credit freed by `res_valid` in cycle t allows `cmd_valid` in t+1.
- `done` is asserted the cycle after DRAIN sees `outst==0`.
- `busy` is registered from the state.
- `ARESET` mid-job returns everything to reset values on the next edge.

## Structure
- Package `gemv_q8_pkg`:
  - `sched_state_e` enum: IDLE, ISSUE, DRAIN, DONE.
  - Default `ROW_W`, `BLK_W`, `MAX_OUTST` constants.
  - A `blk_cmd_t` struct {row, blk, first, last}.
- Sub-module `gemv_q8_credit_cnt`: saturating-checked up/down counter with `inc`, `dec` and `clr` inputs and `full`, `empty` and `underflow` outputs. `underflow` drives `err`.
- FSM and index counters live in the top module.

## Test plan
- `n_rows=3`, `n_blks=2`, `cmd_ready` tied 1, `res_valid` 2 cycles after each `cmd_last` → 6 commands: (0,0,F),(0,1,L),(1,0,F),(1,1,L),(2,0,F),(2,1,L); `done` one cycle after the 3rd result; `rows_done=3`.
- `n_rows=6`, `n_blks=1`, `MAX_OUTST=4`, no results returned → exactly 4 commands, each with first=last=1; `cmd_valid` low; one `res_valid` → 5th command on the next cycle.
- `cmd_ready` toggling 1/0 every cycle, `n_rows=2`, `n_blks=3` → command fields stable across stalls; 6 handshakes in order.
- `start` with `n_blks=0` → `done` and `err` asserted together one cycle later; no `cmd_valid`; `rows_done=0`.
- `abort` mid-ISSUE after 3 commands → IDLE next cycle, `cmd_valid=0`, no `done`; a new `start` runs normally from (0,0).
- `res_valid` while idle with `outst=0` → one `err` pulse; `rows_done` unchanged. A last-row `res_valid` coinciding with a `cmd_last` handshake leaves `outst` unchanged.
